// File: rtl/piso_tx_pkg.sv
// Shared types and sizing helpers for the piso_tx serializer.
// Optional even-parity bit controlled by macro PISO_TX_PARITY_EN.
package piso_tx_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Number of serial bit cycles per word, including the optional parity bit.
  function automatic int unsigned frame_len(input int unsigned width);
`ifdef PISO_TX_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  function automatic int unsigned cnt_width(input int unsigned flen);
    return (flen > 1) ? $clog2(flen) : 1;
  endfunction

endpackage

// File: rtl/piso_tx_shreg.sv
// WIDTH-bit load / shift-right register; bit 0 is the serial output tap.
module piso_tx_shreg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             sin_i,
  output logic             lsb_o
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= din_i;
    end else if (shift_i) begin
      sr_q <= {sin_i, sr_q[WIDTH-1:1]};
    end
  end

  assign lsb_o = sr_q[0];

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter, LSB first, valid/ready word input.
// Define PISO_TX_PARITY_EN to append an even-parity bit to every word.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA,
  input  logic             VALID,
  output logic             READY,
  output logic             O,
  output logic             FRAME
);

  localparam int unsigned FRAME_LEN = frame_len(WIDTH);
  localparam int unsigned CNT_W     = cnt_width(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_q, frame_d;
  logic             load_c, shift_c, sin_c;
`ifdef PISO_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign READY = (state_q == IDLE) || (cnt_q == LAST);

  // Next-state: a handshake always reloads; otherwise advance or fall back to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    load_c  = 1'b0;
    shift_c = 1'b0;
    sin_c   = 1'b0;
`ifdef PISO_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (VALID && READY) begin
      state_d = SHIFT;
      cnt_d   = '0;
      frame_d = 1'b1;
      load_c  = 1'b1;
`ifdef PISO_TX_PARITY_EN
      par_d   = ^DATA;
`endif
    end else if (state_q == SHIFT) begin
      shift_c = 1'b1;
      if (cnt_q == LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
        frame_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
`ifdef PISO_TX_PARITY_EN
        // Parity enters the MSB on the first shift so it reaches bit 0 right after bit WIDTH-1.
        sin_c = (cnt_q == '0) ? par_q : 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frame_q <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
`ifdef PISO_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  piso_tx_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk     (CLK),
    .rst     (RESET),
    .load_i  (load_c),
    .shift_i (shift_c),
    .din_i   (DATA),
    .sin_i   (sin_c),
    .lsb_o   (O)
  );

  assign FRAME = frame_q;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: queue-based bit-stream model, directed scenarios and random traffic.
module tb_piso_tx;

  localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         CLK = 1'b0;
  logic         RESET;
  logic [W-1:0] DATA;
  logic         VALID;
  logic         READY;
  logic         O;
  logic         FRAME;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  bit exp_q[$];
  logic [7:0]  chain;
  logic [31:0] cap;

  piso_tx #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .DATA  (DATA),
    .VALID (VALID),
    .READY (READY),
    .O     (O),
    .FRAME (FRAME)
  );

  always #5 CLK = ~CLK;

  // External serial-in chain: the first bit sent ends up in chain[0].
  always @(posedge CLK) chain <= {O, chain[7:1]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: the pending serial bits of the current and any queued word.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      exp_q.delete();
    end else begin
      bit rdy;
      rdy = (exp_q.size() <= 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (VALID && rdy) begin
        for (int b = 0; b < W; b++) exp_q.push_back(DATA[b]);
`ifdef PISO_TX_PARITY_EN
        exp_q.push_back(^DATA);
`endif
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("ready", 32'(READY), 32'(exp_q.size() <= 1));
      check("frame", 32'(FRAME), 32'(exp_q.size() > 0));
      check("o",     32'(O),     32'((exp_q.size() > 0) ? exp_q[0] : 1'b0));
    end
  end

  // Accept a word from IDLE, then record O over FL cycles; returns at cycle FL+1.
  task automatic send_capture(input logic [W-1:0] d);
    VALID = 1'b1;
    DATA  = d;
    @(negedge CLK);
    VALID = 1'b0;
    cap = '0;
    for (int i = 1; i <= FL; i++) begin
      cap[i-1] = O;
      @(negedge CLK);
    end
  endtask

  initial begin
    RESET = 1'b1;
    VALID = 1'b0;
    DATA  = '0;
    @(negedge CLK);
    check("rst_o", 32'(O), 32'(0));
    check("rst_frame", 32'(FRAME), 32'(0));
    check("rst_ready", 32'(READY), 32'(1));
    @(negedge CLK);
    #1 RESET = 1'b0;
    chk_en = 1'b1;
    @(negedge CLK);

    // Single word A5 with READY/FRAME timing and loopback chain.
    VALID = 1'b1;
    DATA  = 8'hA5;
    @(negedge CLK);
    VALID = 1'b0;
    cap = '0;
    for (int i = 1; i <= FL + 1; i++) begin
      if (i <= FL) begin
        cap[i-1] = O;
        check("single_frame", 32'(FRAME), 32'(1));
        check("single_ready", 32'(READY), 32'(i == FL));
      end else begin
        check("single_end_frame", 32'(FRAME), 32'(0));
        check("single_end_o", 32'(O), 32'(0));
      end
      if (i == 9) check("loopback", 32'(chain), 32'h0000_00A5);
      @(negedge CLK);
    end
    check("single_bits", 32'(cap[7:0]), 32'h0000_00A5);
`ifdef PISO_TX_PARITY_EN
    check("single_par", 32'(cap[8]), 32'(0));
`endif

    // Back-to-back 01 then 80 with VALID held.
    VALID = 1'b1;
    DATA  = 8'h01;
    @(negedge CLK);
    DATA = 8'h80;
    cap = '0;
    for (int i = 1; i <= 2 * FL + 1; i++) begin
      if (i == FL + 1) VALID = 1'b0;
      if (i <= 2 * FL) begin
        cap[i-1] = O;
        check("b2b_frame", 32'(FRAME), 32'(1));
      end else begin
        check("b2b_end_frame", 32'(FRAME), 32'(0));
      end
      @(negedge CLK);
    end
`ifdef PISO_TX_PARITY_EN
    check("b2b_bits", cap, 32'h0003_0101);
`else
    check("b2b_bits", cap, 32'h0000_8001);
`endif

    // Busy ignore: VALID with FF on cycle 3 must not disturb the 5A frame.
    VALID = 1'b1;
    DATA  = 8'h5A;
    @(negedge CLK);
    VALID = 1'b0;
    cap = '0;
    for (int i = 1; i <= FL + 3; i++) begin
      VALID = (i == 3);
      if (i == 3) DATA = 8'hFF;
      if (i <= FL) cap[i-1] = O;
      else check("busy_no_extra", 32'(FRAME), 32'(0));
      @(negedge CLK);
    end
    VALID = 1'b0;
    check("busy_bits", 32'(cap[7:0]), 32'h0000_005A);

    // Reset on cycle 4 of FF, between edges; then 03 must come out intact.
    VALID = 1'b1;
    DATA  = 8'hFF;
    @(negedge CLK);
    VALID = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    check("midrst_o", 32'(O), 32'(0));
    check("midrst_frame", 32'(FRAME), 32'(0));
    check("midrst_ready", 32'(READY), 32'(1));
    VALID = 1'b1;
    DATA  = 8'h55;
    @(negedge CLK);
    check("rst_no_accept", 32'(FRAME), 32'(0));
    #1 RESET = 1'b0;
    send_capture(8'h03);
    check("after_rst_bits", 32'(cap[7:0]), 32'h0000_0003);
    check("after_rst_idle", 32'(FRAME), 32'(0));

`ifdef PISO_TX_PARITY_EN
    send_capture(8'h07);
    check("par_07", 32'(cap[8:0]), 32'h0000_0107);
    send_capture(8'h03);
    check("par_03", 32'(cap[8:0]), 32'h0000_0003);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge CLK);
      #1;
      RESET = ($urandom_range(0, 199) == 0);
      VALID = ($urandom_range(0, 9) < 6);
      DATA  = W'($urandom);
    end
    @(negedge CLK);
    #1;
    RESET = 1'b0;
    VALID = 1'b0;
    repeat (FL + 2) @(negedge CLK);
    check("final_idle", 32'(FRAME), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
